// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states and common pipeline words.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_EX_HOLD = 2'd2
    } state_e;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] INST_NOP  = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_hold_watchdog.sv
// EX-hold watchdog: counts held cycles, forces a release at the terminal count,
// keeps a sticky timeout flag and masks the request until it drops once.
module pipe_ctrl_hold_watchdog #(
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic count_en_i,
    input  logic req_i,
    output logic tc_o,
    output logic ignore_o,
    output logic timeout_o
);

    localparam logic [15:0] WD_TC = 16'(HOLD_TIMEOUT - 1);

    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        timeout_q, timeout_d;
    logic        ignore_q, ignore_d;

    assign tc_o      = (wd_cnt_q == WD_TC);
    assign ignore_o  = ignore_q;
    assign timeout_o = timeout_q;

    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        ignore_d  = ignore_q;
        if (clr_i) begin
            wd_cnt_d = 16'd0;
        end else if (count_en_i) begin
            if (tc_o) begin
                wd_cnt_d  = 16'd0;
                timeout_d = 1'b1;
                ignore_d  = 1'b1;
            end else begin
                wd_cnt_d = wd_cnt_q + 16'd1;
            end
        end
        // count_en implies the request is high, so this never fights the set above
        if (!req_i) begin
            ignore_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wd_cnt_q  <= 16'd0;
            timeout_q <= 1'b0;
            ignore_q  <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
            ignore_q  <= ignore_d;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates bus stalls, redirects, EX holds and load-use
// hazards into per-stage hold/flush controls and the PC redirect.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        ex_hold_req_i,
    input  logic        load_use_i,
    input  logic        bus_stall_i,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        hold_id_ex_o,
    output logic        hold_ex_me_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        flush_ex_me_o,
    output logic        pc_jump_o,
    output logic [31:0] pc_jump_addr_o,
    output logic        hold_timeout_o
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic        pend_jump_q, pend_jump_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic wd_clr, wd_count_en, wd_tc, wd_ignore, wd_timeout;

    pipe_ctrl_hold_watchdog #(
        .HOLD_TIMEOUT(HOLD_TIMEOUT)
    ) u_hold_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (wd_clr),
        .count_en_i(wd_count_en),
        .req_i     (ex_hold_req_i),
        .tc_o      (wd_tc),
        .ignore_o  (wd_ignore),
        .timeout_o (wd_timeout)
    );

    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        pend_jump_d    = pend_jump_q;
        pend_addr_d    = pend_addr_q;
        wd_clr         = 1'b0;
        wd_count_en    = 1'b0;
        hold_pc_o      = 1'b0;
        hold_if_id_o   = 1'b0;
        hold_id_ex_o   = 1'b0;
        hold_ex_me_o   = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        flush_ex_me_o  = 1'b0;
        pc_jump_o      = 1'b0;
        pc_jump_addr_o = ZERO_WORD;
        hold_timeout_o = wd_timeout;

        if (bus_stall_i) begin
            hold_pc_o    = 1'b1;
            hold_if_id_o = 1'b1;
            hold_id_ex_o = 1'b1;
            hold_ex_me_o = 1'b1;
            // an already parked jump is older and kills anything behind it
            if (jump_flag_i && !pend_jump_q) begin
                pend_jump_d = 1'b1;
                pend_addr_d = jump_addr_i;
            end
        end else if (jump_flag_i || pend_jump_q) begin
            pc_jump_o      = 1'b1;
            flush_if_id_o  = 1'b1;
            flush_id_ex_o  = 1'b1;
            flush_ex_me_o  = 1'b1;
            pc_jump_addr_o = pend_jump_q ? pend_addr_q : jump_addr_i;
            pend_jump_d    = 1'b0;
            wd_clr         = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d     = ST_FLUSH;
                flush_cnt_d = FLUSH_LOAD;
            end else begin
                state_d     = ST_RUN;
                flush_cnt_d = 4'd0;
            end
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    if (flush_cnt_q <= 4'd1) begin
                        flush_cnt_d = 4'd0;
                        state_d     = ST_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 4'd1;
                    end
                end
                ST_EX_HOLD: begin
                    if (ex_hold_req_i) begin
                        hold_pc_o     = 1'b1;
                        hold_if_id_o  = 1'b1;
                        hold_id_ex_o  = 1'b1;
                        flush_ex_me_o = 1'b1;
                        wd_count_en   = 1'b1;
                        if (wd_tc) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        wd_clr  = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    if (ex_hold_req_i && !wd_ignore) begin
                        hold_pc_o     = 1'b1;
                        hold_if_id_o  = 1'b1;
                        hold_id_ex_o  = 1'b1;
                        flush_ex_me_o = 1'b1;
                        wd_count_en   = 1'b1;
                        state_d       = ST_EX_HOLD;
                    end else if (load_use_i) begin
                        hold_pc_o     = 1'b1;
                        hold_if_id_o  = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end
                end
            endcase
        end

        // reset is active-high on rst_n; every output is forced quiet while it is asserted
        if (rst_n) begin
            hold_pc_o      = 1'b0;
            hold_if_id_o   = 1'b0;
            hold_id_ex_o   = 1'b0;
            hold_ex_me_o   = 1'b0;
            flush_if_id_o  = 1'b0;
            flush_id_ex_o  = 1'b0;
            flush_ex_me_o  = 1'b0;
            pc_jump_o      = 1'b0;
            pc_jump_addr_o = ZERO_WORD;
            hold_timeout_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 4'd0;
            pend_jump_q <= 1'b0;
            pend_addr_q <= ZERO_WORD;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            pend_jump_q <= pend_jump_d;
            pend_addr_q <= pend_addr_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a cycle-by-cycle vector table plus hand sequences
// for the watchdog timeout and multi-cycle flush.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, jump_flag_i, ex_hold_req_i, load_use_i, bus_stall_i;
    logic [31:0] jump_addr_i;

    logic        a_hpc, a_hifid, a_hidex, a_hexme, a_fifid, a_fidex, a_fexme, a_pcj, a_to;
    logic        b_hpc, b_hifid, b_hidex, b_hexme, b_fifid, b_fidex, b_fexme, b_pcj, b_to;
    logic [31:0] a_addr, b_addr;
    logic [8:0]  ctl_a, ctl_b;

    int n_total = 0;
    int n_pass  = 0;

    // ctl bit order: hold_pc, hold_if_id, hold_id_ex, hold_ex_me,
    //                flush_if_id, flush_id_ex, flush_ex_me, pc_jump, hold_timeout
    localparam logic [8:0] C_NONE  = 9'h000;
    localparam logic [8:0] C_JUMP  = 9'h01E;
    localparam logic [8:0] C_STALL = 9'h1E0;
    localparam logic [8:0] C_EXH   = 9'h1C4;
    localparam logic [8:0] C_LU    = 9'h188;
    localparam logic [8:0] C_FL    = 9'h018;
    localparam logic [8:0] C_TO    = 9'h001;

    typedef struct {
        logic        rst;
        logic        jf;
        logic [31:0] addr;
        logic        exh;
        logic        lu;
        logic        bs;
        logic [8:0]  ctl;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    assign ctl_a = {a_hpc, a_hifid, a_hidex, a_hexme, a_fifid, a_fidex, a_fexme, a_pcj, a_to};
    assign ctl_b = {b_hpc, b_hifid, b_hidex, b_hexme, b_fifid, b_fidex, b_fexme, b_pcj, b_to};

    pipe_ctrl #(.FLUSH_CYCLES(1), .HOLD_TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .ex_hold_req_i(ex_hold_req_i), .load_use_i(load_use_i), .bus_stall_i(bus_stall_i),
        .hold_pc_o(a_hpc), .hold_if_id_o(a_hifid), .hold_id_ex_o(a_hidex), .hold_ex_me_o(a_hexme),
        .flush_if_id_o(a_fifid), .flush_id_ex_o(a_fidex), .flush_ex_me_o(a_fexme),
        .pc_jump_o(a_pcj), .pc_jump_addr_o(a_addr), .hold_timeout_o(a_to)
    );

    pipe_ctrl #(.FLUSH_CYCLES(3), .HOLD_TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .ex_hold_req_i(ex_hold_req_i), .load_use_i(load_use_i), .bus_stall_i(bus_stall_i),
        .hold_pc_o(b_hpc), .hold_if_id_o(b_hifid), .hold_id_ex_o(b_hidex), .hold_ex_me_o(b_hexme),
        .flush_if_id_o(b_fifid), .flush_id_ex_o(b_fidex), .flush_ex_me_o(b_fexme),
        .pc_jump_o(b_pcj), .pc_jump_addr_o(b_addr), .hold_timeout_o(b_to)
    );

    function automatic vec_t mk(input logic r, input logic jf, input logic [31:0] a,
                                input logic exh, input logic lu, input logic bs,
                                input logic [8:0] ctl, input logic [31:0] ea);
        vec_t v;
        v.rst = r; v.jf = jf; v.addr = a; v.exh = exh; v.lu = lu; v.bs = bs;
        v.ctl = ctl; v.exp_addr = ea;
        return v;
    endfunction

    // drive one cycle of inputs, check mid-cycle, then advance past the next edge
    task automatic run_cycle(input string name, input int idx, input logic use_b, input vec_t v);
        logic [8:0]  act_ctl;
        logic [31:0] act_addr;
        rst_n = v.rst; jump_flag_i = v.jf; jump_addr_i = v.addr;
        ex_hold_req_i = v.exh; load_use_i = v.lu; bus_stall_i = v.bs;
        #4;
        act_ctl  = use_b ? ctl_b  : ctl_a;
        act_addr = use_b ? b_addr : a_addr;
        n_total++;
        if (act_ctl === v.ctl) n_pass++;
        else $display("FAIL %s[%0d] ctl: got %b expected %b", name, idx, act_ctl, v.ctl);
        n_total++;
        if (act_addr === v.exp_addr) n_pass++;
        else $display("FAIL %s[%0d] addr: got %h expected %h", name, idx, act_addr, v.exp_addr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; jump_flag_i = 1'b1; jump_addr_i = 32'hFFFF_FFFF;
        ex_hold_req_i = 1'b1; load_use_i = 1'b1; bus_stall_i = 1'b1;
        @(posedge clk);
        #1;

        //                rst jf  addr          exh lu  bs  ctl      exp_addr
        vecs.push_back(mk(1, 1, 32'hFFFF_FFFF, 1, 1, 1, C_NONE,  32'h0));
        vecs.push_back(mk(1, 1, 32'hFFFF_FFFF, 1, 1, 1, C_NONE,  32'h0));
        vecs.push_back(mk(1, 1, 32'hFFFF_FFFF, 1, 1, 1, C_NONE,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, C_NONE,  32'h0));
        vecs.push_back(mk(0, 1, 32'h0000_0100, 0, 0, 0, C_JUMP,  32'h100));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, C_NONE,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, C_STALL, 32'h0));
        vecs.push_back(mk(0, 1, 32'h0000_0200, 0, 0, 1, C_STALL, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, C_STALL, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 1, C_STALL, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, C_JUMP,  32'h200));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, C_NONE,  32'h0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 0, 32'h0,     1, 0, 0, C_EXH,   32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, C_NONE,  32'h0));
        vecs.push_back(mk(0, 1, 32'h0000_0300, 0, 1, 0, C_JUMP,  32'h300));
        vecs.push_back(mk(0, 0, 32'h0,         0, 1, 0, C_LU,    32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, C_NONE,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, C_EXH,   32'h0));
        vecs.push_back(mk(0, 1, 32'h0000_0400, 1, 0, 0, C_JUMP,  32'h400));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, C_NONE,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, C_EXH,   32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         1, 0, 1, C_STALL, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         1, 0, 0, C_EXH,   32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, C_NONE,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 1, 1, C_STALL, 32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, C_NONE,  32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         1, 1, 0, C_EXH,   32'h0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 0, 0, C_NONE,  32'h0));

        foreach (vecs[i]) run_cycle("table", i, 1'b0, vecs[i]);

        // watchdog: exactly 8 held cycles, then the still-high request is ignored
        for (int k = 0; k < 20; k++)
            run_cycle("timeout", k, 1'b0, mk(0, 0, 32'h0, 1, 0, 0, (k < 8) ? C_EXH : C_TO, 32'h0));
        run_cycle("to_drop", 0, 1'b0, mk(0, 0, 32'h0, 0, 0, 0, C_TO, 32'h0));
        run_cycle("to_drop", 1, 1'b0, mk(0, 0, 32'h0, 0, 0, 0, C_TO, 32'h0));
        run_cycle("to_rearm", 0, 1'b0, mk(0, 0, 32'h0, 1, 0, 0, C_EXH | C_TO, 32'h0));
        run_cycle("to_rearm", 1, 1'b0, mk(0, 0, 32'h0, 0, 0, 0, C_TO, 32'h0));
        run_cycle("to_reset", 0, 1'b0, mk(1, 0, 32'h0, 0, 0, 0, C_NONE, 32'h0));
        run_cycle("to_reset", 1, 1'b0, mk(0, 0, 32'h0, 0, 0, 0, C_NONE, 32'h0));

        // three-cycle flush on the second instance: stall freezes, hazards ignored, jump reloads
        run_cycle("flush", 0, 1'b1, mk(0, 1, 32'h0000_0500, 0, 0, 0, C_JUMP,  32'h500));
        run_cycle("flush", 1, 1'b1, mk(0, 0, 32'h0,         1, 1, 0, C_FL,    32'h0));
        run_cycle("flush", 2, 1'b1, mk(0, 0, 32'h0,         0, 0, 1, C_STALL, 32'h0));
        run_cycle("flush", 3, 1'b1, mk(0, 0, 32'h0,         0, 1, 0, C_FL,    32'h0));
        run_cycle("flush", 4, 1'b1, mk(0, 0, 32'h0,         0, 0, 0, C_NONE,  32'h0));
        run_cycle("flush", 5, 1'b1, mk(0, 1, 32'h0000_0600, 0, 0, 0, C_JUMP,  32'h600));
        run_cycle("flush", 6, 1'b1, mk(0, 1, 32'h0000_0700, 0, 0, 0, C_JUMP,  32'h700));
        run_cycle("flush", 7, 1'b1, mk(0, 0, 32'h0,         0, 0, 0, C_FL,    32'h0));
        run_cycle("flush", 8, 1'b1, mk(0, 0, 32'h0,         0, 0, 0, C_FL,    32'h0));
        run_cycle("flush", 9, 1'b1, mk(0, 0, 32'h0,         0, 0, 0, C_NONE,  32'h0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
